// File: rtl/regfile_dump_reader_if.sv
// Beat stream from the register-file dump reader to the debug/trace sink.
// master drives the beat, slave returns ready.
interface regfile_dump_reader_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    logic              dump_valid_o;
    logic              dump_ready_i;
    logic [ADDR_W-1:0] dump_addr_o;
    logic [XLEN-1:0]   dump_data_o;
    logic              dump_last_o;

    modport master (
        output dump_valid_o,
        output dump_addr_o,
        output dump_data_o,
        output dump_last_o,
        input  dump_ready_i
    );

    modport slave (
        input  dump_valid_o,
        input  dump_addr_o,
        input  dump_data_o,
        input  dump_last_o,
        output dump_ready_i
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks x0..x(NREGS-1) through an async regfile read port and streams beats.
// Optional REGDUMP_CHECKSUM_EN adds checksum_o, XOR of all accepted beats.
module regfile_dump_reader #(
    parameter int NREGS  = 32,
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic [ADDR_W-1:0]     rf_addr_o,
    input  logic [XLEN-1:0]       rf_data_i,
    regfile_dump_reader_if.master dump,
    output logic                  busy_o,
`ifdef REGDUMP_CHECKSUM_EN
    output logic [XLEN-1:0]       checksum_o,
`endif
    output logic                  done_o
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_t;

    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NREGS - 1);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

    state_t          state;
    logic [ADDR_W:0] idx;
    logic            capture;
    logic            hs;

    // Output slot is free or emptying this cycle: safe to load the next beat.
    assign capture   = (state == SCAN) &&
                       (!dump.dump_valid_o || dump.dump_ready_i);
    assign hs        = dump.dump_valid_o && dump.dump_ready_i;
    assign busy_o    = (state != IDLE);
    assign rf_addr_o = (state == SCAN) ? idx[ADDR_W-1:0] : '0;

    // Scan FSM, beat output register and optional checksum accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            idx               <= '0;
            done_o            <= 1'b0;
            dump.dump_valid_o <= 1'b0;
            dump.dump_addr_o  <= '0;
            dump.dump_data_o  <= '0;
            dump.dump_last_o  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            checksum_o        <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            if (abort_i && state != IDLE) begin
                state             <= IDLE;
                idx               <= '0;
                dump.dump_valid_o <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                checksum_o        <= '0;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start_i && !abort_i) begin
                            state <= SCAN;
                            idx   <= '0;
`ifdef REGDUMP_CHECKSUM_EN
                            checksum_o <= '0;
`endif
                        end
                    end
                    SCAN: begin
`ifdef REGDUMP_CHECKSUM_EN
                        if (hs) checksum_o <= checksum_o ^ dump.dump_data_o;
`endif
                        if (capture) begin
                            dump.dump_valid_o <= 1'b1;
                            dump.dump_addr_o  <= idx[ADDR_W-1:0];
                            dump.dump_data_o  <= rf_data_i;
                            dump.dump_last_o  <= (idx == LAST);
                            idx               <= idx + ONE;
                            if (idx == LAST) state <= DRAIN;
                        end else if (hs) begin
                            dump.dump_valid_o <= 1'b0;
                        end
                    end
                    DRAIN: begin
                        if (hs) begin
                            dump.dump_valid_o <= 1'b0;
                            state             <= IDLE;
                            done_o            <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                            checksum_o <= checksum_o ^ dump.dump_data_o;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: directed dumps, backpressure,
// stall coherency, abort, reset, ignored start and optional checksum.
module tb_regfile_dump_reader;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        busy;
    logic        done;
`ifdef REGDUMP_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] rf [32];
    beat_t       q[$];
    int          n_cmp;
    int          n_bad;
    int          done_cnt;
    int          beat_cnt;
    logic        bp_en;
    int          bp_ph;

    regfile_dump_reader_if #(.XLEN(32), .ADDR_W(5)) dif ();

    regfile_dump_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .abort_i   (abort),
        .rf_addr_o (rf_addr),
        .rf_data_i (rf_data),
        .dump      (dif),
        .busy_o    (busy),
`ifdef REGDUMP_CHECKSUM_EN
        .checksum_o(checksum),
`endif
        .done_o    (done)
    );

    assign rf_data = (rf_addr == 5'd0) ? 32'h0 : rf[rf_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push_range(input int n, input logic [31:0] base);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.a = 5'(i);
            b.d = (i == 0) ? 32'h0 : base + 32'(i);
            b.l = (i == 31);
            q.push_back(b);
        end
    endtask

    task automatic fill_rf(input logic [31:0] base);
        for (int i = 0; i < 32; i++) rf[i] = base + 32'(i);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (n < max) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        if (n >= max) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got none want pulse");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pop and compare each accepted beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !abort && dif.dump_valid_o && dif.dump_ready_i) begin
                beat_cnt++;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got addr %0d want none",
                             dif.dump_addr_o);
                end else begin
                    e = q.pop_front();
                    check("beat_addr", 64'(dif.dump_addr_o), 64'(e.a));
                    check("beat_data", 64'(dif.dump_data_o), 64'(e.d));
                    check("beat_last", 64'(dif.dump_last_o), 64'(e.l));
                end
            end
            if (done) done_cnt++;
        end
    end

    // Ready pattern 1,0,0,1 while backpressure mode is on.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (bp_en) begin
                dif.dump_ready_i = (bp_ph == 0 || bp_ph == 3);
                bp_ph = (bp_ph + 1) % 4;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got hang want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        int b0;
        n_cmp = 0; n_bad = 0; done_cnt = 0; beat_cnt = 0;
        bp_en = 1'b0; bp_ph = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        dif.dump_ready_i = 1'b1;
        fill_rf(32'h1000_0000);
        idle(2);
        @(negedge clk);
        check("rst_valid", 64'(dif.dump_valid_o), 64'd0);
        check("rst_addr", 64'(dif.dump_addr_o), 64'd0);
        check("rst_data", 64'(dif.dump_data_o), 64'd0);
        check("rst_last", 64'(dif.dump_last_o), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rfaddr", 64'(rf_addr), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Basic dump at full throughput.
        push_range(32, 32'h1000_0000);
        b0 = beat_cnt;
        pulse_start();
        wait_done(100, n);
        check("basic_done_cycle", 64'(n), 64'd33);
        check("basic_busy_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        check("basic_done_width", 64'(done), 64'd0);
        check("basic_beats", 64'(beat_cnt - b0), 64'd32);
        check("basic_q_empty", 64'(q.size()), 64'd0);

        // Backpressure.
        idle(2);
        push_range(32, 32'h1000_0000);
        b0 = beat_cnt;
        bp_ph = 0;
        bp_en = 1'b1;
        pulse_start();
        wait_done(300, n);
        bp_en = 1'b0;
        idle(1);
        dif.dump_ready_i = 1'b1;
        check("bp_beats", 64'(beat_cnt - b0), 64'd32);
        check("bp_q_empty", 64'(q.size()), 64'd0);

        // Register write while beat x5 is held.
        idle(2);
        fill_rf(32'hAAAA_0000);
        push_range(32, 32'hAAAA_0000);
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (dif.dump_valid_o && dif.dump_addr_o == 5'd5) begin
                dif.dump_ready_i = 1'b0;
                break;
            end
        end
        idle(2);
        rf[5] = 32'h5555_0005;
        idle(2);
        @(negedge clk);
        check("stall_valid", 64'(dif.dump_valid_o), 64'd1);
        check("stall_addr", 64'(dif.dump_addr_o), 64'd5);
        check("stall_data", 64'(dif.dump_data_o), 64'h0000_0000_AAAA_0005);
        @(posedge clk); #1 dif.dump_ready_i = 1'b1;
        wait_done(100, n);
        check("stall_q_empty", 64'(q.size()), 64'd0);

        // Abort after beat 10 is accepted.
        idle(2);
        fill_rf(32'h1000_0000);
        push_range(11, 32'h1000_0000);
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (dif.dump_valid_o && dif.dump_addr_o == 5'd11) begin
                abort = 1'b1;
                break;
            end
        end
        @(negedge clk);
        @(negedge clk);
        check("abort_valid", 64'(dif.dump_valid_o), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        abort = 1'b0;
        idle(3);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_q_empty", 64'(q.size()), 64'd0);
        push_range(32, 32'h1000_0000);
        pulse_start();
        wait_done(100, n);
        check("restart_done_cycle", 64'(n), 64'd33);
        check("restart_q_empty", 64'(q.size()), 64'd0);

        // Reset mid-scan.
        idle(2);
        push_range(32, 32'h1000_0000);
        d0 = done_cnt;
        pulse_start();
        idle(8);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 64'(dif.dump_valid_o), 64'd0);
        check("mrst_addr", 64'(dif.dump_addr_o), 64'd0);
        check("mrst_data", 64'(dif.dump_data_o), 64'd0);
        check("mrst_last", 64'(dif.dump_last_o), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_rfaddr", 64'(rf_addr), 64'd0);
        idle(2);
        q.delete();
        rst_n = 1'b1;
        idle(40);
        check("mrst_no_done", 64'(done_cnt - d0), 64'd0);

        // Start while busy is ignored.
        push_range(32, 32'h1000_0000);
        d0 = done_cnt;
        pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(100, n);
        check("busy_start_done_cycle", 64'(n), 64'd31);
        idle(40);
        check("busy_start_one_done", 64'(done_cnt - d0), 64'd1);
        check("busy_start_q_empty", 64'(q.size()), 64'd0);

`ifdef REGDUMP_CHECKSUM_EN
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[1] = 32'h0000_00FF;
        rf[2] = 32'h0000_0F0F;
        push_range(1, 32'h0);
        push_range(0, 32'h0);
        begin
            beat_t b;
            b.a = 5'd1; b.d = 32'h0000_00FF; b.l = 1'b0; q.push_back(b);
            b.a = 5'd2; b.d = 32'h0000_0F0F; b.l = 1'b0; q.push_back(b);
            for (int i = 3; i < 32; i++) begin
                b.a = 5'(i); b.d = 32'h0; b.l = (i == 31); q.push_back(b);
            end
        end
        pulse_start();
        wait_done(100, n);
        check("csum_at_done", 64'(checksum), 64'h0000_0FF0);
        idle(3);
        check("csum_hold", 64'(checksum), 64'h0000_0FF0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug read-out engine for the RV32I integer register file. On a start request it walks read addresses x0..x31 through one asynchronous register-file read port, snapshots each value into an output register, and streams (address, data) beats over a valid/ready interface to the debug/trace sink. It sits beside the core datapath and consumes the register-file read side, while the core owns the write side.

## Interface
- NREGS, 32, number of registers scanned (addresses 0..NREGS-1)
- XLEN, 32, data width of each beat
- ADDR_W, 5, width of register addresses
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  level-sampled request; accepted only in IDLE
- abort_i  in  1  cancel the scan in progress
- rf_addr_o  out  ADDR_W  register-file read address
- rf_data_i  in  XLEN  register-file read data, combinational from rf_addr_o
- dump_valid_o  out  1  beat available
- dump_ready_i  in  1  sink accepts beat
- dump_addr_o  out  ADDR_W  register index of the beat
- dump_data_o  out  XLEN  register value of the beat
- dump_last_o  out  1  beat is index NREGS-1
- busy_o  out  1  high in SCAN and DRAIN
- done_o  out  1  one-cycle pulse after the last beat is accepted

## Operation
- States:
  - IDLE. start_i goes to SCAN with idx=0.
  - SCAN. Issues reads; goes to DRAIN after idx NREGS-1 is captured.
  - DRAIN. Waits for the last handshake, then returns to IDLE and pulses done_o.
- rf_addr_o = idx in SCAN; 0 otherwise.
- Capture condition in SCAN: (!dump_valid_o || dump_ready_i).
  - On capture, load dump_addr_o=idx, dump_data_o=rf_data_i, dump_last_o=(idx==NREGS-1), and set dump_valid_o=1.
  - Then increment idx.
  - idx is ADDR_W+1 bits wide, so it never wraps at 31.
- Handshake = dump_valid_o && dump_ready_i.
  - A handshake with no capture in the same cycle clears dump_valid_o.
  - When a handshake and a capture happen together, a new beat is loaded and dump_valid_o stays 1. Throughput is 1 beat/cycle.
- Stall: while dump_valid_o && !dump_ready_i, dump_addr_o, dump_data_o and dump_last_o hold stable. Later register-file writes do not alter a beat that is already held.
- Coherency:
  - Each register is snapshotted at its own capture edge.
  - The scan is not atomic across registers. The core should be halted for a coherent dump.
- x0 is emitted like any other index, with whatever rf_data_i returns (0 from a compliant file).
- start_i while busy_o=1 is ignored.
- abort_i in SCAN/DRAIN:
  - Next edge returns to IDLE and clears dump_valid_o and idx.
  - No done_o pulse.
  - abort_i has priority over a same-cycle handshake or capture.
  - abort_i in IDLE has no effect. If abort_i and start_i are both high in IDLE, start_i is ignored.

## Timing
- Reset values (all outputs): dump_valid_o=0, dump_addr_o=0, dump_data_o=0, dump_last_o=0, busy_o=0, done_o=0, rf_addr_o=0. Reset also sets state=IDLE, idx=0.
- Reset mid-scan: immediate return to IDLE, with no done_o pulse and no further beats.
- With start_i sampled at edge E0:
  - Beat x0 is valid after E1.
  - With dump_ready_i held at 1, beat k is presented after E(k+1) and accepted at E(k+2).
  - done_o is high for the single cycle after E(NREGS+1).
  - busy_o is 0 in the cycle done_o is high.
- Back-to-back: the earliest new start_i is sampled at the edge ending the done_o cycle.

## Configuration
- REGDUMP_CHECKSUM_EN defined:
  - Adds output checksum_o [XLEN-1:0], the XOR of all accepted dump_data_o values.
  - The accumulator clears on start acceptance, abort and reset.
  - checksum_o is stable and valid while done_o=1, and holds until the next start.
- REGDUMP_CHECKSUM_EN undefined: no checksum_o port and no accumulator logic.

## Test plan
- Basic dump:
  - Stimulus: preload x1..x31 = 32'h1000_0000+i, ready=1, pulse start_i.
  - Required: 32 consecutive beats, addr 0..31, data 0 for x0 and 32'h1000_0000+i otherwise. dump_last_o only on addr 31. done_o one cycle at E33.
- Backpressure:
  - Stimulus: ready toggles 1,0,0,1 repeating.
  - Required: every beat held stable while stalled; no beat dropped or duplicated; 32 beats total.
- Write during stall:
  - Stimulus: stall on beat x5 (value 32'hAAAA_0005), then write x5=32'h5555_0005.
  - Required: the held beat still shows 32'hAAAA_0005.
- Abort:
  - Stimulus: assert abort_i after beat 10 is accepted.
  - Required: next cycle dump_valid_o=0 and busy_o=0; no done_o; a fresh start_i restarts at addr 0.
- Reset and ignored start:
  - Stimulus: deassert rst_n mid-scan, and separately pulse start_i while busy.
  - Required: all outputs return to 0 immediately on reset; a start_i while busy causes no restart.
- Checksum (REGDUMP_CHECKSUM_EN):
  - Stimulus: x1=32'h0000_00FF, x2=32'h0000_0F0F, all others 0.
  - Required: checksum_o=32'h0000_0FF0 during done_o.
